// File: rtl/control_unit.sv
// control_unit: instruction sequencer driving the datapath control word.
// Each instruction runs FETCH -> INC -> EXEC; LD/ST stretch EXEC until
// mem_ready, HALT parks the sequencer until reset.
// Optional build macro: CTRL_STEP_EN adds a single-step input that gates FETCH.
module control_unit #(
  parameter logic [2:0] FS_ADD   = 3'd0,
  parameter logic [2:0] FS_PASSA = 3'd6,
  parameter logic [2:0] FS_PASSB = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] I,
  input  logic [3:0]  alu_status_latched,
  input  logic        mem_ready,
`ifdef CTRL_STEP_EN
  input  logic        step,
`endif
  output logic [21:0] control_word,
  output logic [7:0]  K,
  output logic [7:0]  mem_addr,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INC, S_EXEC, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_LDI  = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_JMP  = 4'h5,
    OP_BR   = 4'h6,
    OP_HALT = 4'hF
  } opcode_e;

  // Field order matches control_word bit 21 down to bit 0.
  typedef struct packed {
    logic       sl;
    logic       il;
    logic       pcl;
    logic       mr;
    logic       mw;
    logic       b_sel;
    logic       a_sel;
    logic       en_alu;
    logic       ci;
    logic [2:0] fs;
    logic       w;
    logic [2:0] sb;
    logic [2:0] sa;
    logic [2:0] da;
  } cw_t;

  state_e  state_q, state_d;
  cw_t     cw;
  opcode_e op;
  logic    fetch_go;
  logic    br_take;

`ifdef CTRL_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign op           = opcode_e'(I[15:12]);
  assign br_take      = alu_status_latched[I[9:8]] ^ I[10];
  assign control_word = cw;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and control decode from current state and instruction.
  always_comb begin
    state_d  = state_q;
    cw       = '0;
    K        = '0;
    mem_addr = '0;
    halted   = 1'b0;
    state    = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        state   = 2'd0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        state = 2'd1;
        if (fetch_go) begin
          cw.il   = 1'b1;
          state_d = S_INC;
        end
      end
      S_INC: begin
        state     = 2'd2;
        cw.a_sel  = 1'b1;
        cw.b_sel  = 1'b1;
        cw.fs     = FS_ADD;
        cw.en_alu = 1'b1;
        cw.pcl    = 1'b1;
        K         = 8'd1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        state   = 2'd3;
        state_d = S_FETCH;
        case (op)
          OP_ALU: begin
            cw.da     = I[11:9];
            cw.sa     = I[8:6];
            cw.sb     = I[5:3];
            cw.fs     = I[2:0];
            cw.w      = 1'b1;
            cw.en_alu = 1'b1;
            cw.sl     = 1'b1;
          end
          OP_LDI: begin
            cw.da     = I[10:8];
            cw.b_sel  = 1'b1;
            cw.fs     = FS_PASSB;
            cw.en_alu = 1'b1;
            cw.w      = 1'b1;
            K         = I[7:0];
          end
          OP_LD: begin
            cw.da    = I[10:8];
            cw.mr    = 1'b1;
            cw.w     = mem_ready;
            mem_addr = I[7:0];
            if (!mem_ready) state_d = S_EXEC;
          end
          OP_ST: begin
            cw.sa     = I[10:8];
            cw.fs     = FS_PASSA;
            cw.en_alu = 1'b1;
            cw.mw     = 1'b1;
            mem_addr  = I[7:0];
            if (!mem_ready) state_d = S_EXEC;
          end
          OP_JMP, OP_BR: begin
            if (op == OP_JMP || br_take) begin
              cw.b_sel  = 1'b1;
              cw.fs     = FS_PASSB;
              cw.en_alu = 1'b1;
              cw.pcl    = 1'b1;
              K         = I[7:0];
            end
          end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_HALT: begin
        state  = 2'd3;
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: decode table, hand-written timing sequences and a
// randomized run against a phase-level reference model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] I;
  logic [3:0]  flags;
  logic        mem_ready;
  logic        step;
  logic [21:0] cw;
  logic [7:0]  K;
  logic [7:0]  mem_addr;
  logic        halted;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                (clk),
    .rst                (rst),
    .I                  (I),
    .alu_status_latched (flags),
    .mem_ready          (mem_ready),
`ifdef CTRL_STEP_EN
    .step               (step),
`endif
    .control_word       (cw),
    .K                  (K),
    .mem_addr           (mem_addr),
    .halted             (halted),
    .state              (state)
  );

  typedef struct {
    logic [21:0] cw;
    logic [7:0]  k;
    logic [7:0]  addr;
    logic        halted;
    logic [1:0]  st;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  fl;
    logic        rdy;
    logic [21:0] cw;
    logic [7:0]  k;
    logic [7:0]  addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] bit_at(input int p);
    logic [21:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [21:0] fld(input logic [2:0] v, input int p);
    return {19'd0, v} << p;
  endfunction

  // Phases: 0 idle, 1 fetch, 2 increment, 3 execute, 4 halted.
  function automatic exp_t model(input int ph, input logic [15:0] ins, input logic [3:0] fl,
                                 input logic rdy, input logic stp);
    exp_t        e;
    int          op;
    logic [21:0] jump;
    e.cw     = '0;
    e.k      = '0;
    e.addr   = '0;
    e.halted = (ph == 4);
    e.st     = (ph >= 3) ? 2'd3 : 2'(ph);
    op       = int'(ins[15:12]);
    jump     = bit_at(19) | bit_at(16) | bit_at(14) | fld(3'd7, 10);
    if (ph == 1) begin
      if (stp) e.cw = bit_at(20);
    end else if (ph == 2) begin
      e.cw = bit_at(19) | bit_at(16) | bit_at(15) | bit_at(14);
      e.k  = 8'd1;
    end else if (ph == 3) begin
      case (op)
        1: e.cw = bit_at(21) | bit_at(14) | bit_at(9) | fld(ins[2:0], 10)
                | fld(ins[5:3], 6) | fld(ins[8:6], 3) | fld(ins[11:9], 0);
        2: begin
          e.cw = bit_at(16) | bit_at(14) | bit_at(9) | fld(3'd7, 10) | fld(ins[10:8], 0);
          e.k  = ins[7:0];
        end
        3: begin
          e.cw   = bit_at(18) | fld(ins[10:8], 0) | (rdy ? bit_at(9) : 22'd0);
          e.addr = ins[7:0];
        end
        4: begin
          e.cw   = bit_at(17) | bit_at(14) | fld(3'd6, 10) | fld(ins[10:8], 3);
          e.addr = ins[7:0];
        end
        5: begin
          e.cw = jump;
          e.k  = ins[7:0];
        end
        6: if ((fl[ins[9:8]] ^ ins[10]) == 1'b1) begin
          e.cw = jump;
          e.k  = ins[7:0];
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic int model_next(input int ph, input logic [15:0] ins, input logic rdy,
                                    input logic stp);
    bit mem_op;
    mem_op = (ins[15:12] == 4'h3) || (ins[15:12] == 4'h4);
    case (ph)
      0: return 1;
      1: return stp ? 2 : 1;
      2: return 3;
      3: begin
        if (ins[15:12] == 4'hF) return 4;
        if (mem_op && !rdy) return 3;
        return 1;
      end
      default: return 4;
    endcase
  endfunction

  // Pulse reset then clock three edges: IDLE -> FETCH -> INC -> EXEC.
  task automatic go_exec();
    rst = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vt[16];
  int   nv;
  exp_t e;
  int   ph;

  initial begin
    rst = 1'b0; I = '0; flags = '0; mem_ready = 1'b0; step = 1'b1;

    // Reset state.
    #2;
    chk("reset_cw", 32'(cw), 32'h0);
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_k_addr", {16'd0, K, mem_addr}, 32'h0);

    // EXEC decode table.
    nv = 0;
    vt[nv++] = '{16'h0123, 4'h0, 1'b0, 22'h000000, 8'h00, 8'h00};
    vt[nv++] = '{16'h2A05, 4'h0, 1'b0, 22'h015E02, 8'h05, 8'h00};
    vt[nv++] = '{16'h1288, 4'h0, 1'b0, 22'h204251, 8'h00, 8'h00};
    vt[nv++] = '{16'h1E6D, 4'hF, 1'b1, 22'h20574F, 8'h00, 8'h00};
    vt[nv++] = '{16'h3110, 4'h0, 1'b0, 22'h040001, 8'h00, 8'h10};
    vt[nv++] = '{16'h3110, 4'h0, 1'b1, 22'h040201, 8'h00, 8'h10};
    vt[nv++] = '{16'h4310, 4'h0, 1'b0, 22'h025818, 8'h00, 8'h10};
    vt[nv++] = '{16'h5077, 4'h0, 1'b0, 22'h095C00, 8'h77, 8'h00};
    vt[nv++] = '{16'h6020, 4'h1, 1'b0, 22'h095C00, 8'h20, 8'h00};
    vt[nv++] = '{16'h6020, 4'h0, 1'b0, 22'h000000, 8'h00, 8'h00};
    vt[nv++] = '{16'h6420, 4'h0, 1'b0, 22'h095C00, 8'h20, 8'h00};
    vt[nv++] = '{16'h6420, 4'h1, 1'b0, 22'h000000, 8'h00, 8'h00};
    vt[nv++] = '{16'h6240, 4'h4, 1'b0, 22'h095C00, 8'h40, 8'h00};
    vt[nv++] = '{16'h6340, 4'h7, 1'b0, 22'h000000, 8'h00, 8'h00};
    vt[nv++] = '{16'hF000, 4'h0, 1'b0, 22'h000000, 8'h00, 8'h00};
    vt[nv++] = '{16'hABCD, 4'hF, 1'b1, 22'h000000, 8'h00, 8'h00};
    for (int v = 0; v < nv; v++) begin
      go_exec();
      I = vt[v].ins; flags = vt[v].fl; mem_ready = vt[v].rdy;
      #1;
      chk($sformatf("tbl%0d_cw", v), 32'(cw), 32'(vt[v].cw));
      chk($sformatf("tbl%0d_k_addr", v), {16'd0, K, mem_addr}, {16'd0, vt[v].k, vt[v].addr});
      chk($sformatf("tbl%0d_state", v), 32'(state), 32'h3);
    end

    // INC cycle, with I changing during FETCH/INC having no effect.
    rst = 1'b0; #1; @(posedge clk); #1; rst = 1'b1; I = 16'h3110;
    @(posedge clk); #1; I = 16'hFFFF;
    chk("fetch_cw", 32'(cw), 32'h100000);
    @(posedge clk); #1; I = 16'h5077;
    chk("inc_cw", 32'(cw), 32'h09C000);
    chk("inc_k", 32'(K), 32'h1);
    chk("inc_state", 32'(state), 32'h2);

    // LD wait: three not-ready cycles, then ready, then FETCH.
    go_exec();
    I = 16'h3110; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ldwait%0d_cw", c), 32'(cw), 32'h040001);
      chk($sformatf("ldwait%0d_state", c), 32'(state), 32'h3);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; #1;
    chk("ld_ready_cw", 32'(cw), 32'h040201);
    @(posedge clk); #1; mem_ready = 1'b0; #1;
    chk("ld_after_state", 32'(state), 32'h1);

    // Reset during LD wait.
    go_exec();
    I = 16'h3110; mem_ready = 1'b0; #1;
    chk("ldwait_mr", 32'(cw[18]), 32'h1);
    rst = 1'b0; #1;
    chk("midreset_cw", 32'(cw), 32'h0);
    chk("midreset_state", 32'(state), 32'h0);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("release_idle", 32'(state), 32'h0);
    @(posedge clk); #1;
    chk("release_fetch", 32'(cw), 32'h100000);

    // NOP takes exactly three cycles per instruction.
    go_exec();
    I = 16'h0000; #1;
    chk("nop_exec_state", 32'(state), 32'h3);
    @(posedge clk); #1;
    chk("nop_next_fetch", 32'(state), 32'h1);

    // HALT persists for 20 cycles whatever the inputs do.
    go_exec();
    I = 16'hF000; #1;
    chk("halt_exec_halted", 32'(halted), 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      I = 16'($urandom); mem_ready = 1'($urandom_range(0, 1)); #1;
      chk($sformatf("halt%0d", c), {7'd0, halted, 2'd0, state, cw}, {7'd0, 1'b1, 2'd0, 2'd3, 22'd0});
      @(posedge clk); #1;
    end

`ifdef CTRL_STEP_EN
    // FETCH held while step is low; one step pulse advances.
    step = 1'b0;
    rst = 1'b0; #1; @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stephold%0d", c), {8'd0, state, cw}, {8'd0, 2'd1, 22'd0});
      @(posedge clk); #1;
    end
    step = 1'b1; #1;
    chk("step_il", 32'(cw), 32'h100000);
    @(posedge clk); #1; step = 1'b0;
    chk("step_inc", 32'(state), 32'h2);
    step = 1'b1;
`endif

    // Randomized run against the phase model.
    rst = 1'b0; ph = 0; #1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 24) != 0);
      if (ph != 3) begin
        I     = 16'($urandom);
        flags = 4'($urandom);
      end
      mem_ready = 1'($urandom_range(0, 1));
`ifdef CTRL_STEP_EN
      step = ($urandom_range(0, 3) != 0);
`endif
      if (!rst) ph = 0;
      #1;
      e = model(ph, I, flags, mem_ready, step);
      chk("rnd_cw", 32'(cw), 32'(e.cw));
      chk("rnd_k", 32'(K), 32'(e.k));
      chk("rnd_addr", 32'(mem_addr), 32'(e.addr));
      chk("rnd_halted", 32'(halted), 32'(e.halted));
      chk("rnd_state", 32'(state), 32'(e.st));
      chk("rnd_exclusive", 32'((cw[14] & cw[18]) | (cw[19] & cw[9])), 32'h0);
      ph = rst ? model_next(ph, I, mem_ready, step) : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
